// File: rtl/ddr_wr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_wr_pkg
//  Function : FSM encoding, burst-length codes and DQS level constants for the
//             DDR write-burst transmit path.
//  Revision : 1.0
// ============================================================================
package ddr_wr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_PRE  = 3'd2,
        ST_DATA = 3'd3,
        ST_POST = 3'd4
    } state_t;

    localparam logic [1:0] c_bl2 = 2'b00;
    localparam logic [1:0] c_bl4 = 2'b01;
    localparam logic [1:0] c_bl8 = 2'b10;

    // {d0, d1} levels of the DQS output flop
    localparam logic [1:0] c_dqs_pre  = 2'b00;
    localparam logic [1:0] c_dqs_data = 2'b10;
    localparam logic [1:0] c_dqs_post = 2'b00;

    function automatic logic [2:0] bl_beats(input logic [1:0] code);
        case (code)
            c_bl2:   bl_beats = 3'd1;
            c_bl4:   bl_beats = 3'd2;
            c_bl8:   bl_beats = 3'd4;
            default: bl_beats = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_wr_burst_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_wr_burst_tx
//  Function : DDR write-burst transmitter: write latency, DQS preamble, data
//             beats and postamble feeding the per-bit DDR output flops.
//  Revision : 1.0
// ============================================================================
module ddr_wr_burst_tx #(
    parameter int DQ_W = 16,
    parameter int DM_W = DQ_W / 8,
    parameter int WL   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_bl,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [2*DQ_W-1:0]   wr_data,
    input  logic [2*DM_W-1:0]   wr_mask,
    output logic [DQ_W-1:0]     dq_d0,
    output logic [DQ_W-1:0]     dq_d1,
    output logic                dq_oe,
    output logic [DM_W-1:0]     dm_d0,
    output logic [DM_W-1:0]     dm_d1,
    output logic                dqs_d0,
    output logic                dqs_d1,
    output logic                dqs_oe,
    output logic                busy,
    output logic                burst_done,
    output logic                underrun,
    input  logic                underrun_clr
);
    import ddr_wr_pkg::*;

    localparam logic [2:0] c_wl_m1 = 3'(WL - 1);

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_cnt, w_cnt_nxt;
    logic [1:0]       r_bl, w_bl_nxt;
    logic [DQ_W-1:0]  r_dq_d0, r_dq_d1, w_dq_d0_nxt, w_dq_d1_nxt;
    logic [DM_W-1:0]  r_dm_d0, r_dm_d1, w_dm_d0_nxt, w_dm_d1_nxt;
    logic             r_dqs_d0, r_dqs_d1, w_dqs_d0_nxt, w_dqs_d1_nxt;
    logic             r_dq_oe, r_dqs_oe, w_dq_oe_nxt, w_dqs_oe_nxt;
    logic             r_burst_done, w_burst_done_nxt;
    logic             r_underrun, w_underrun_nxt;
    logic             w_beat;

    // A beat is loaded at the edge closing PRE and every DATA cycle but the last
    assign w_beat = (r_state == ST_PRE) || ((r_state == ST_DATA) && (r_cnt != 3'd0));

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_bl_nxt         = r_bl;
        w_dq_d0_nxt      = r_dq_d0;
        w_dq_d1_nxt      = r_dq_d1;
        w_dm_d0_nxt      = r_dm_d0;
        w_dm_d1_nxt      = r_dm_d1;
        w_dqs_d0_nxt     = r_dqs_d0;
        w_dqs_d1_nxt     = r_dqs_d1;
        w_dq_oe_nxt      = r_dq_oe;
        w_dqs_oe_nxt     = r_dqs_oe;
        w_burst_done_nxt = 1'b0;
        w_underrun_nxt   = r_underrun;

        if (w_beat && !wr_valid) begin
            w_underrun_nxt = 1'b1;
        end else if (underrun_clr) begin
            w_underrun_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_bl_nxt    = cmd_bl;
                    w_cnt_nxt   = c_wl_m1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt                  = ST_PRE;
                    w_dqs_oe_nxt                 = 1'b1;
                    w_dq_oe_nxt                  = 1'b0;
                    {w_dqs_d0_nxt, w_dqs_d1_nxt} = c_dqs_pre;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            ST_PRE: begin
                w_state_nxt = ST_DATA;
                w_cnt_nxt   = bl_beats(r_bl) - 3'd1;
            end
            ST_DATA: begin
                if (r_cnt != 3'd0) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else begin
                    w_state_nxt                  = ST_POST;
                    w_dqs_oe_nxt                 = 1'b1;
                    w_dq_oe_nxt                  = 1'b0;
                    {w_dqs_d0_nxt, w_dqs_d1_nxt} = c_dqs_post;
                    w_dm_d0_nxt                  = '1;
                    w_dm_d1_nxt                  = '1;
                    w_burst_done_nxt             = 1'b1;
                end
            end
            ST_POST: begin
                w_state_nxt  = ST_IDLE;
                w_dqs_oe_nxt = 1'b0;
                w_dq_oe_nxt  = 1'b0;
                w_dqs_d0_nxt = 1'b0;
                w_dqs_d1_nxt = 1'b0;
                w_dm_d0_nxt  = '1;
                w_dm_d1_nxt  = '1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A starved beat still goes out: DQ holds, every byte masked
        if (w_beat) begin
            w_dq_oe_nxt                  = 1'b1;
            w_dqs_oe_nxt                 = 1'b1;
            {w_dqs_d0_nxt, w_dqs_d1_nxt} = c_dqs_data;
            if (wr_valid) begin
                w_dq_d0_nxt = wr_data[DQ_W-1:0];
                w_dq_d1_nxt = wr_data[2*DQ_W-1:DQ_W];
                w_dm_d0_nxt = wr_mask[DM_W-1:0];
                w_dm_d1_nxt = wr_mask[2*DM_W-1:DM_W];
            end else begin
                w_dm_d0_nxt = '1;
                w_dm_d1_nxt = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 3'd0;
            r_bl         <= 2'b00;
            r_dq_d0      <= '0;
            r_dq_d1      <= '0;
            r_dm_d0      <= '1;
            r_dm_d1      <= '1;
            r_dqs_d0     <= 1'b0;
            r_dqs_d1     <= 1'b0;
            r_dq_oe      <= 1'b0;
            r_dqs_oe     <= 1'b0;
            r_burst_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bl         <= w_bl_nxt;
            r_dq_d0      <= w_dq_d0_nxt;
            r_dq_d1      <= w_dq_d1_nxt;
            r_dm_d0      <= w_dm_d0_nxt;
            r_dm_d1      <= w_dm_d1_nxt;
            r_dqs_d0     <= w_dqs_d0_nxt;
            r_dqs_d1     <= w_dqs_d1_nxt;
            r_dq_oe      <= w_dq_oe_nxt;
            r_dqs_oe     <= w_dqs_oe_nxt;
            r_burst_done <= w_burst_done_nxt;
            r_underrun   <= w_underrun_nxt;
        end
    end

    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = !cmd_ready;
    assign wr_ready   = w_beat;
    assign dq_d0      = r_dq_d0;
    assign dq_d1      = r_dq_d1;
    assign dm_d0      = r_dm_d0;
    assign dm_d1      = r_dm_d1;
    assign dqs_d0     = r_dqs_d0;
    assign dqs_d1     = r_dqs_d1;
    assign dq_oe      = r_dq_oe;
    assign dqs_oe     = r_dqs_oe;
    assign burst_done = r_burst_done;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire
